// File: rtl/rtcomp_mesh_mc.sv
// rtcomp_mesh_mc: route computation for unicast and bitmask-multicast headers
// on a MESH_X x MESH_Y mesh. A multicast mask is split into per-port sub-masks
// issued one per cycle, in the order local, east, west, north, south.
// Optional build macro RTCOMP_YX_EN switches dimension order from XY to YX.
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1.
// The producer holds its payload stable while valid=1 and ready=0, and valid
// never depends combinationally on ready.
module rtcomp_mesh_mc #(
  parameter int MESH_X  = 4,
  parameter int MESH_Y  = 4,
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int NUM_VC  = 2,
  localparam int N      = MESH_X * MESH_Y,
  localparam int IDW    = $clog2(N),
  localparam int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_type,
  input  logic [VCW-1:0] in_vch,
  input  logic [IDW-1:0] in_udst,
  input  logic [N-1:0]   in_mdst,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2:0]     out_port,
  output logic [VCW-1:0] out_vch,
  output logic [N-1:0]   out_mdst,
  output logic           out_last,
  output logic           err
);

  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;

  // Dimension-order routing decision for a destination at (x, y).
  function automatic logic [2:0] route_of(input int x, input int y);
`ifdef RTCOMP_YX_EN
    if (y > MY_YPOS)      return 3'd3;
    else if (y < MY_YPOS) return 3'd4;
    else if (x > MY_XPOS) return 3'd1;
    else if (x < MY_XPOS) return 3'd2;
    else                  return 3'd0;
`else
    if (x > MY_XPOS)      return 3'd1;
    else if (x < MY_XPOS) return 3'd2;
    else if (y > MY_YPOS) return 3'd3;
    else if (y < MY_YPOS) return 3'd4;
    else                  return 3'd0;
`endif
  endfunction

  // route_sel[p][i] is a constant: node i leaves through port p.
  logic [N-1:0] route_sel [5];
  for (genvar p = 0; p < 5; p++) begin : g_port
    for (genvar i = 0; i < N; i++) begin : g_node
      assign route_sel[p][i] = (route_of(i % MESH_X, i / MESH_X) == 3'(p));
    end
  end

  logic [N-1:0] grp_q    [5];  // groups still to be issued for this header
  logic [N-1:0] src_grp  [5];
  logic [N-1:0] nxt_grp  [5];
  logic [N-1:0] uni_mask;
  logic [N-1:0] hdr_mask;
  logic [N-1:0] pick_mask;
  logic [4:0]   nonempty;
  logic [4:0]   rem;
  logic [2:0]   pick;
  logic         any_grp;
  logic         nxt_last;

  assign in_ready = (state == IDLE);

  // Group selection: fresh groups while idle, pending groups while emitting.
  // A unicast header becomes a one-hot mask so both kinds share one path;
  // an out-of-range unicast id gives an empty mask and is flagged illegal.
  always_comb begin
    uni_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (in_udst == IDW'(i)) uni_mask[i] = 1'b1;
    end
    hdr_mask = in_type ? in_mdst : uni_mask;
    for (int p = 0; p < 5; p++) begin
      src_grp[p]  = in_ready ? (hdr_mask & route_sel[p]) : grp_q[p];
      nonempty[p] = |src_grp[p];
    end
    any_grp = |nonempty;
    pick = 3'd0;
    for (int p = 4; p >= 0; p--) begin
      if (nonempty[p]) pick = 3'(p);
    end
    rem       = nonempty & ~(5'b00001 << pick);
    nxt_last  = (rem == 5'd0);
    pick_mask = src_grp[pick];
    for (int p = 0; p < 5; p++) begin
      nxt_grp[p] = (pick == 3'(p)) ? '0 : src_grp[p];
    end
  end

  // Control FSM with registered request outputs and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_port  <= 3'd0;
      out_vch   <= '0;
      out_mdst  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      for (int p = 0; p < 5; p++) grp_q[p] <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!any_grp) begin
              err <= 1'b1;
            end else begin
              out_valid <= 1'b1;
              out_port  <= pick;
              out_vch   <= in_vch;
              out_mdst  <= in_type ? pick_mask : '0;
              out_last  <= nxt_last;
              for (int p = 0; p < 5; p++) grp_q[p] <= nxt_grp[p];
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              out_port <= pick;
              out_mdst <= pick_mask;
              out_last <= nxt_last;
              for (int p = 0; p < 5; p++) grp_q[p] <= nxt_grp[p];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtcomp_mesh_mc.sv
// Directed testbench for rtcomp_mesh_mc: a 4x4 instance at (1,1) and a 3x3
// instance at (1,1) whose id space leaves room for out-of-range unicast ids.
module tb_rtcomp_mesh_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4x4 instance
  logic        in_valid = 1'b0, in_type = 1'b0, out_ready = 1'b0;
  logic        in_vch = 1'b0;
  logic [3:0]  in_udst = '0;
  logic [15:0] in_mdst = '0;
  logic        in_ready, out_valid, out_last, err, out_vch;
  logic [2:0]  out_port;
  logic [15:0] out_mdst;

  // 3x3 instance
  logic        b_in_valid = 1'b0, b_in_type = 1'b0, b_out_ready = 1'b1;
  logic        b_in_vch = 1'b0;
  logic [3:0]  b_in_udst = '0;
  logic [8:0]  b_in_mdst = '0;
  logic        b_in_ready, b_out_valid, b_out_last, b_err, b_out_vch;
  logic [2:0]  b_out_port;
  logic [8:0]  b_out_mdst;

  int n_checks = 0;
  int n_fail   = 0;

  // expected multicast sequence for mask 0xA0B2 at (1,1)
  logic [2:0]  exp_port [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [15:0] exp_mask [5] = '{16'h0020, 16'h8080, 16'h0010, 16'h2000, 16'h0002};

  rtcomp_mesh_mc #(.MESH_X(4), .MESH_Y(4), .MY_XPOS(1), .MY_YPOS(1), .NUM_VC(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_vch(in_vch), .in_udst(in_udst), .in_mdst(in_mdst), .out_valid(out_valid),
    .out_ready(out_ready), .out_port(out_port), .out_vch(out_vch), .out_mdst(out_mdst),
    .out_last(out_last), .err(err)
  );

  rtcomp_mesh_mc #(.MESH_X(3), .MESH_Y(3), .MY_XPOS(1), .MY_YPOS(1), .NUM_VC(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_type(b_in_type),
    .in_vch(b_in_vch), .in_udst(b_in_udst), .in_mdst(b_in_mdst), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_port(b_out_port), .out_vch(b_out_vch), .out_mdst(b_out_mdst),
    .out_last(b_out_last), .err(b_err)
  );

  // advance one clock and land just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", err); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    n_checks++; if (out_port !== 3'd0 || out_mdst !== 16'h0 || out_last !== 1'b0 || out_vch !== 1'b0) begin
      n_fail++; $display("FAIL reset_payload got port=%0d mdst=%h last=%0b vch=%0b exp 0", out_port, out_mdst, out_last, out_vch);
    end
    n_checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_b got in_ready=%0b out_valid=%0b exp 1/0", b_in_ready, b_out_valid);
    end
  endtask

  task automatic test_unicast();
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 1'b0; in_udst = 4'd7; in_vch = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL uni_valid got %0b exp 1", out_valid); end
    n_checks++; if (out_port !== 3'd1) begin n_fail++; $display("FAIL uni_port got %0d exp 1", out_port); end
    n_checks++; if (out_vch !== 1'b1) begin n_fail++; $display("FAIL uni_vch got %0b exp 1", out_vch); end
    n_checks++; if (out_mdst !== 16'h0) begin n_fail++; $display("FAIL uni_mdst got %h exp 0", out_mdst); end
    n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL uni_last got %0b exp 1", out_last); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL uni_in_ready got %0b exp 0", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_port !== 3'd1) begin
      n_fail++; $display("FAIL uni_stall got valid=%0b in_ready=%0b port=%0d exp 1/0/1", out_valid, in_ready, out_port);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL uni_done got valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic check_mc_sequence(input logic vch_exp);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_port !== exp_port[k] || out_mdst !== exp_mask[k] ||
          out_last !== (k == 4) || in_ready !== 1'b0 || out_vch !== vch_exp) begin
        n_fail++;
        $display("FAIL mc_req%0d got v=%0b port=%0d mdst=%h last=%0b rdy=%0b vch=%0b exp v=1 port=%0d mdst=%h last=%0b rdy=0 vch=%0b",
                 k, out_valid, out_port, out_mdst, out_last, in_ready, out_vch, exp_port[k], exp_mask[k], (k == 4), vch_exp);
      end
      step();
    end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mc_end got valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_multicast();
    out_ready = 1'b1;
    in_valid = 1'b1; in_type = 1'b1; in_mdst = 16'hA0B2; in_vch = 1'b0;
    step();
    in_valid = 1'b0;
    check_mc_sequence(1'b0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 1'b1; in_mdst = 16'hA0B2; in_vch = 1'b1;
    step();
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_port !== 3'd0 || out_mdst !== 16'h0020 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%0b port=%0d mdst=%h last=%0b rdy=%0b exp 1/0/0020/0/0",
                 s, out_valid, out_port, out_mdst, out_last, in_ready);
      end
      if (s < 2) step();
    end
    out_ready = 1'b1;
    check_mc_sequence(1'b1);
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    // out-of-range unicast ids on the 3x3 mesh (N=9)
    for (int t = 0; t < 2; t++) begin
      b_in_valid = 1'b1; b_in_type = 1'b0; b_in_udst = (t == 0) ? 4'd9 : 4'd15;
      step();
      b_in_valid = 1'b0;
      n_checks++; if (b_err !== 1'b1 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL ill_uni%0d got err=%0b valid=%0b rdy=%0b exp 1/0/1", t, b_err, b_out_valid, b_in_ready);
      end
      step();
      n_checks++; if (b_err !== 1'b0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL ill_uni%0d_after got err=%0b valid=%0b rdy=%0b exp 0/0/1", t, b_err, b_out_valid, b_in_ready);
      end
    end
    // highest legal id (8 = (2,2)) on the 3x3 mesh
    b_in_valid = 1'b1; b_in_type = 1'b0; b_in_udst = 4'd8;
    step();
    b_in_valid = 1'b0;
    n_checks++;
`ifdef RTCOMP_YX_EN
    if (b_err !== 1'b0 || b_out_valid !== 1'b1 || b_out_port !== 3'd3) begin
      n_fail++; $display("FAIL legal_max got err=%0b valid=%0b port=%0d exp 0/1/3", b_err, b_out_valid, b_out_port);
    end
`else
    if (b_err !== 1'b0 || b_out_valid !== 1'b1 || b_out_port !== 3'd1) begin
      n_fail++; $display("FAIL legal_max got err=%0b valid=%0b port=%0d exp 0/1/1", b_err, b_out_valid, b_out_port);
    end
`endif
    step();
    // empty multicast mask on the 4x4 mesh
    in_valid = 1'b1; in_type = 1'b1; in_mdst = 16'h0000;
    step();
    in_valid = 1'b0;
    n_checks++; if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ill_mc got err=%0b valid=%0b rdy=%0b exp 1/0/1", err, out_valid, in_ready);
    end
    step();
    n_checks++; if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ill_mc_after got err=%0b valid=%0b rdy=%0b exp 0/0/1", err, out_valid, in_ready);
    end
  endtask

  task automatic test_dim_order();
    logic [2:0] exp_p;
`ifdef RTCOMP_YX_EN
    exp_p = 3'd3;
`else
    exp_p = 3'd1;
`endif
    out_ready = 1'b1;
    in_valid = 1'b1; in_type = 1'b0; in_udst = 4'd15; in_vch = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_port !== exp_p || out_last !== 1'b1) begin
      n_fail++; $display("FAIL dim_order got valid=%0b port=%0d last=%0b exp 1/%0d/1", out_valid, out_port, out_last, exp_p);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_type = 1'b0; in_udst = 4'd4; in_vch = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_port !== 3'd2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first got valid=%0b port=%0d rdy=%0b exp 1/2/0", out_valid, out_port, in_ready);
    end
    step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap got valid=%0b rdy=%0b exp 0/1", out_valid, in_ready);
    end
    in_udst = 4'd1; in_vch = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_port !== 3'd4 || out_vch !== 1'b0 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got valid=%0b port=%0d vch=%0b last=%0b exp 1/4/0/1", out_valid, out_port, out_vch, out_last);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_emit();
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 1'b1; in_mdst = 16'hA0B2; in_vch = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mdst !== 16'h0 || out_vch !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got valid=%0b rdy=%0b mdst=%h vch=%0b exp 0/1/0/0", out_valid, in_ready, out_mdst, out_vch);
    end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after got valid=%0b exp 0", out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before test completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_illegal();
    test_dim_order();
    test_back_to_back();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
